pc_stack_unit: RTL
==================

# pc_stack_unit

Parametrised program-counter unit for the Veri_RISC control path with an integrated hardware return-address stack. It supports increment, skip (+2), absolute load, subroutine call and return, and flags stack overflow and underflow. It sits between the controller (which issues one-hot-ish control strobes) and the instruction-memory address bus.

## Interface
Parameters:
- ADDR_W, 8, PC and address width in bits (≥2).
- STACK_DEPTH, 4, number of return-address entries (≥1).
- RESET_ADDR, 0, value loaded into the PC on reset (ADDR_W bits).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ld_pc  input  1  absolute load: PC ← pc_in.
- inc_pc  input  1  PC ← PC + 1.
- skip_pc  input  1  PC ← PC + 2.
- call  input  1  push PC + 1, then PC ← pc_in.
- ret  input  1  PC ← popped entry.
- err_clr  input  1  clears the sticky error flags.
- pc_in  input  ADDR_W  target address for ld_pc and call.
- pc_addr  output  ADDR_W  current PC (registered).
- stack_cnt  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  stack_cnt == STACK_DEPTH.
- stack_empty  output  1  stack_cnt == 0.
- err_ovf  output  1  sticky: a call was attempted while the stack was full.
- err_unf  output  1  sticky: a ret was attempted while the stack was empty.

## Operation
- Reset (rst_n low, asynchronous):
  - pc_addr = RESET_ADDR, stack_cnt = 0, err_ovf = 0, err_unf = 0.
  - Stack contents are don't-care.
  - Reset asserted in the middle of any sequence overrides everything, immediately and without waiting for a clock edge.
- Priority when several strobes are high on the same edge, highest first: call > ret > ld_pc > skip_pc > inc_pc. Only the winning operation takes effect; the others are ignored for that cycle.
- No strobe high: PC and stack hold.
- call:
  - Stack not full: write (pc_addr+1) mod 2^ADDR_W at stack[stack_cnt], then stack_cnt++ and pc_addr ← pc_in.
  - Stack full: no push, PC holds, err_ovf ← 1.
- ret:
  - Stack not empty: pc_addr ← stack[stack_cnt-1] and stack_cnt--.
  - Stack empty: PC holds, err_unf ← 1.
- ld_pc: pc_addr ← pc_in. The stack is untouched.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W.
  - Increment from all-ones wraps to 0.
  - Skip from all-ones wraps to 1; skip from all-ones minus 1 wraps to 0.
- Stack organisation: LIFO, with the pointer equal to stack_cnt. No circular overwrite.
- Error flags:
  - err_ovf and err_unf stay set until err_clr is sampled high.
  - If err_clr and a new error event occur on the same edge, the flag ends set (set wins).
  - err_clr does not affect the PC or the stack.
- stack_full and stack_empty are decoded combinationally from the stack_cnt register.

## Timing
- Every update takes effect on the clk rising edge on which the strobe is sampled. pc_addr shows the new value after that edge (one-cycle latency). No multi-cycle operations exist.
- A call in cycle N followed by a ret in cycle N+1 returns pc_addr to (old PC + 1) after edge N+1.
- Back-to-back calls are allowed every cycle until the stack is full. The call that fills the stack succeeds; the next call sets err_ovf.
- Flag outputs change only on clock edges or asynchronous reset.

## Test plan
- Reset and increment:
  - Drive rst_n low mid-count, then release it → pc_addr = 0, stack_empty = 1, flags = 0.
  - Then 3 cycles of inc_pc → pc_addr = 3.
- Wrap-around with ADDR_W = 8:
  - ld_pc with pc_in = 0xFF, then inc_pc → 0x00.
  - ld_pc with pc_in = 0xFE, then skip_pc → 0x00.
  - ld_pc with pc_in = 0xFF, then skip_pc → 0x01.
- Nested call and return with STACK_DEPTH = 4:
  - From pc = 0x10, call 0x40; from 0x40, call 0x80 → stack_cnt = 2.
  - ret → 0x41; ret → 0x11; stack_empty = 1.
- Overflow:
  - 4 calls fill the stack (stack_full = 1).
  - A 5th call with pc_in = 0x99 → PC unchanged, stack_cnt = 4, err_ovf = 1.
  - err_clr → err_ovf = 0.
- Underflow and priority:
  - ret with the stack empty → PC holds and err_unf = 1.
  - call, ret and inc_pc asserted together at pc = 0x20 with pc_in = 0x50 → pc_addr = 0x50 and stack_cnt = 1 (call wins).
- Same-edge error clear:
  - err_clr together with an overflowing call → err_ovf remains 1.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Program counter with an integrated LIFO return-address stack.
// Supports increment, skip, load, call and return, with sticky overflow/underflow flags.
module pc_stack_unit #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  localparam int unsigned      CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_pc,
  input  logic              inc_pc,
  input  logic              skip_pc,
  input  logic              call,
  input  logic              ret,
  input  logic              err_clr,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [CNT_W-1:0]  stack_cnt,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err_ovf,
  output logic              err_unf
);

  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CALL,
    OP_RET,
    OP_LD,
    OP_SKIP,
    OP_INC
  } op_e;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  op_e               op;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  cnt_dec;
  logic [PTR_W-1:0]  push_ptr;
  logic [PTR_W-1:0]  pop_ptr;
  logic              push_en;
  logic              ovf_set;
  logic              unf_set;

  assign stack_full  = (stack_cnt == CNT_W'(STACK_DEPTH));
  assign stack_empty = (stack_cnt == '0);

  assign pc_inc   = pc_addr + ADDR_W'(1);
  assign cnt_dec  = stack_cnt - CNT_W'(1);
  // Pointers are only used when the access is legal, so truncation is safe.
  assign push_ptr = stack_cnt[PTR_W-1:0];
  assign pop_ptr  = cnt_dec[PTR_W-1:0];

  always_comb begin
    if (call)         op = OP_CALL;
    else if (ret)     op = OP_RET;
    else if (ld_pc)   op = OP_LD;
    else if (skip_pc) op = OP_SKIP;
    else if (inc_pc)  op = OP_INC;
    else              op = OP_HOLD;
  end

  always_comb begin
    pc_nxt  = pc_addr;
    cnt_nxt = stack_cnt;
    push_en = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_CALL: begin
        if (!stack_full) begin
          push_en = 1'b1;
          cnt_nxt = stack_cnt + CNT_W'(1);
          pc_nxt  = pc_in;
        end else begin
          ovf_set = 1'b1;
        end
      end
      OP_RET: begin
        if (!stack_empty) begin
          pc_nxt  = stack_mem[pop_ptr];
          cnt_nxt = cnt_dec;
        end else begin
          unf_set = 1'b1;
        end
      end
      OP_LD:   pc_nxt = pc_in;
      OP_SKIP: pc_nxt = pc_addr + ADDR_W'(2);
      OP_INC:  pc_nxt = pc_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_addr   <= RESET_ADDR;
      stack_cnt <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
    end else begin
      pc_addr   <= pc_nxt;
      stack_cnt <= cnt_nxt;
      // A new error on the same edge as err_clr leaves the flag set.
      err_ovf   <= ovf_set | (err_ovf & ~err_clr);
      err_unf   <= unf_set | (err_unf & ~err_clr);
    end
  end

  // Stack contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[push_ptr] <= pc_inc;
  end

endmodule
